// File: rtl/lc3_mem_master.sv
// lc3_mem_master
// CPU-side initiator for the LC-3 word memory. Accepts READ / WRITE / READ_IND /
// WRITE_IND requests through a valid/ready handshake and sequences the memory
// cycles. The memory has a one-cycle registered read and commits writes on the
// clock edge that samples mem_write_en. Indirect ops first fetch a pointer from
// req_addr, then use that pointer for the data access.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_op            00 READ, 01 WRITE, 10 READ_IND, 11 WRITE_IND
//   req_addr/wdata    target (or pointer) address, write data
//   resp_valid        one-cycle completion strobe for every op
//   resp_rdata        read result, held until the next read completes
//   busy              high whenever the FSM is not IDLE
//   mem_write_en/addr/wdata  memory command outputs
//   mem_rdata         registered memory read data
module lc3_mem_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RCAP,
        S_RD2,
        S_RCAP2,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_READ_IND  = 2'b10;
    localparam logic [1:0] OP_WRITE_IND = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    // Selects the fetched pointer instead of the request address as the memory
    // address. Only changes at the handshake and at the pointer capture, so
    // mem_addr holds its last value through RESP and IDLE.
    logic              ptr_sel_q, ptr_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ptr_q     <= '0;
            rdata_q   <= '0;
            ptr_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ptr_q     <= ptr_d;
            rdata_q   <= rdata_d;
            ptr_sel_q <= ptr_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ptr_d     = ptr_q;
        rdata_d   = rdata_q;
        ptr_sel_d = ptr_sel_q;
        case (state_q)
            S_IDLE: begin
                // req_ready is 1 here, so req_valid alone is the handshake.
                if (req_valid) begin
                    op_d      = req_op;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    ptr_sel_d = 1'b0;
                    state_d   = (req_op == OP_WRITE) ? S_WR : S_RD;
                end
            end
            S_RD:  state_d = S_RCAP;
            S_RCAP: begin
                case (op_q)
                    OP_READ: begin
                        rdata_d = mem_rdata;
                        state_d = S_RESP;
                    end
                    OP_READ_IND: begin
                        ptr_d     = ADDR_W'(mem_rdata);
                        ptr_sel_d = 1'b1;
                        state_d   = S_RD2;
                    end
                    OP_WRITE_IND: begin
                        ptr_d     = ADDR_W'(mem_rdata);
                        ptr_sel_d = 1'b1;
                        state_d   = S_WR;
                    end
                    default: state_d = S_RESP; // plain WRITE never reads
                endcase
            end
            S_RD2:   state_d = S_RCAP2;
            S_RCAP2: begin
                rdata_d = mem_rdata;
                state_d = S_RESP;
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign resp_valid   = (state_q == S_RESP);
    assign mem_write_en = (state_q == S_WR);
    assign mem_addr     = ptr_sel_q ? ptr_q : addr_q;
    assign mem_wdata    = wdata_q;
    assign resp_rdata   = rdata_q;

endmodule

// File: tb/tb_lc3_mem_master.sv
// Bench for lc3_mem_master: a 64K-word memory model with one-cycle registered
// read, a reference memory updated by op semantics, directed scenarios and a
// randomized back-to-back run with req_valid held high.
module tb_lc3_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        busy;
    logic        mem_write_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // memory model + backdoor preload port
    logic [15:0] mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        clr = 1'b1;
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [15:0] bd_data = '0;

    lc3_mem_master #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (bd_we) mem[bd_addr] <= bd_data;
            else if (mem_write_en) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // Reference semantics: apply op to ref_mem, return the value a read yields.
    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        case (op)
            2'b00: r = ref_mem[a];
            2'b01: ref_mem[a] = w;
            2'b10: r = ref_mem[ref_mem[a]];
            default: ref_mem[ref_mem[a]] = w;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [1:0] op);
        case (op)
            2'b00: return 3;
            2'b01: return 2;
            2'b10: return 5;
            default: return 4;
        endcase
    endfunction

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issues one request, scrambles req_* while busy, measures the response.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] w,
                          output int lat, output logic [15:0] rd, output int wp,
                          output int consec, output logic [15:0] a1, output logic [15:0] a3);
        int n;
        logic pwe;
        logic done;
        logic [15:0] unused_r;
        lat = 0; rd = '0; wp = 0; consec = 0; a1 = '0; a3 = '0; pwe = 1'b0; done = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
        unused_r = model(op, a, w);
        @(negedge clk);
        lat = 1;
        while (!done && lat <= 20) begin
            if (lat == 1) a1 = mem_addr;
            if (lat == 3) a3 = mem_addr;
            if (mem_write_en) begin wp++; if (pwe) consec++; end
            pwe = mem_write_en;
            if (resp_valid) begin
                rd = resp_rdata;
                done = 1'b1;
            end else begin
                req_valid = 1'($urandom);
                req_op    = 2'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b1;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h1234;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_write_en); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", resp_rdata); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_bus addr=%h wdata=%h exp=0000/0000", mem_addr, mem_wdata); end
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_handshake busy=%b exp=0", busy); end
    endtask

    task automatic test_write_read;
        int lat, wp, cs; logic [15:0] rd, a1, a3;
        run_op(2'b01, 16'h3000, 16'hBEEF, lat, rd, wp, cs, a1, a3);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got=%0d exp=2", lat); end
        checks++; if (wp !== 1 || cs !== 0) begin errors++; $display("FAIL write_we_pulses got=%0d consec=%0d exp=1/0", wp, cs); end
        checks++; if (a1 !== 16'h3000) begin errors++; $display("FAIL write_addr got=%h exp=3000", a1); end
        checks++; if (mem[16'h3000] !== 16'hBEEF) begin errors++; $display("FAIL write_mem got=%h exp=beef", mem[16'h3000]); end
        run_op(2'b00, 16'h3000, 16'h0000, lat, rd, wp, cs, a1, a3);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_data got=%h exp=beef", rd); end
        checks++; if (wp !== 0) begin errors++; $display("FAIL read_we got=%0d exp=0", wp); end
        // 0x0000 boundary
        run_op(2'b01, 16'h0000, 16'h1357, lat, rd, wp, cs, a1, a3);
        run_op(2'b00, 16'h0000, 16'hFFFF, lat, rd, wp, cs, a1, a3);
        checks++; if (rd !== 16'h1357) begin errors++; $display("FAIL read_addr0 got=%h exp=1357", rd); end
        @(negedge clk);
        checks++; if (resp_rdata !== 16'h1357) begin errors++; $display("FAIL rdata_hold got=%h exp=1357", resp_rdata); end
    endtask

    task automatic test_read_ind;
        int lat, wp, cs; logic [15:0] rd, a1, a3;
        poke(16'h4000, 16'h5000);
        poke(16'h5000, 16'h1234);
        run_op(2'b10, 16'h4000, 16'h0000, lat, rd, wp, cs, a1, a3);
        checks++; if (a1 !== 16'h4000 || a3 !== 16'h5000) begin errors++; $display("FAIL rind_addr_seq got=%h,%h exp=4000,5000", a1, a3); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL rind_latency got=%0d exp=5", lat); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rind_data got=%h exp=1234", rd); end
        checks++; if (wp !== 0) begin errors++; $display("FAIL rind_we got=%0d exp=0", wp); end
    endtask

    task automatic test_write_ind;
        int lat, wp, cs; logic [15:0] rd, a1, a3;
        poke(16'h4001, 16'hFFFF);
        run_op(2'b11, 16'h4001, 16'hA5A5, lat, rd, wp, cs, a1, a3);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wind_latency got=%0d exp=4", lat); end
        checks++; if (mem[16'hFFFF] !== 16'hA5A5) begin errors++; $display("FAIL wind_target got=%h exp=a5a5", mem[16'hFFFF]); end
        checks++; if (mem[16'h4001] !== 16'hFFFF) begin errors++; $display("FAIL wind_ptr_kept got=%h exp=ffff", mem[16'h4001]); end
        checks++; if (wp !== 1 || a3 !== 16'hFFFF) begin errors++; $display("FAIL wind_we got=%0d addr=%h exp=1/ffff", wp, a3); end
    endtask

    task automatic test_self_ptr;
        int lat, wp, cs; logic [15:0] rd, a1, a3;
        poke(16'h2222, 16'h2222);
        run_op(2'b10, 16'h2222, 16'h0000, lat, rd, wp, cs, a1, a3);
        checks++; if (rd !== 16'h2222 || a3 !== 16'h2222) begin errors++; $display("FAIL self_ptr got=%h addr=%h exp=2222/2222", rd, a3); end
    endtask

    task automatic test_reset_mid;
        int nresp;
        logic [15:0] unused_r;
        poke(16'h4100, 16'h4200);
        poke(16'h4200, 16'h9999);
        // abort READ_IND in RD2
        req_valid = 1'b1; req_op = 2'b10; req_addr = 16'h4100; req_wdata = 16'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_addr !== 16'h4200) begin errors++; $display("FAIL rstmid_rd2_addr got=%h exp=4200", mem_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle busy=%b ready=%b exp=0/1", busy, req_ready); end
        checks++; if (resp_rdata !== 16'h0 || mem_addr !== 16'h0) begin errors++; $display("FAIL rstmid_outs rdata=%h addr=%h exp=0000/0000", resp_rdata, mem_addr); end
        nresp = 0;
        for (int i = 0; i < 6; i++) begin if (resp_valid) nresp++; @(negedge clk); end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL rstmid_no_resp got=%0d exp=0", nresp); end
        // abort WRITE in WR: the write still lands
        req_valid = 1'b1; req_op = 2'b01; req_addr = 16'h6000; req_wdata = 16'h7777;
        unused_r = model(2'b01, 16'h6000, 16'h7777);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL rstmid_wr_we got=%b exp=1", mem_write_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem[16'h6000] !== 16'h7777) begin errors++; $display("FAIL rstmid_wr_commit got=%h exp=7777", mem[16'h6000]); end
        nresp = 0;
        for (int i = 0; i < 6; i++) begin if (resp_valid || busy) nresp++; @(negedge clk); end
        checks++; if (nresp !== 0) begin errors++; $display("FAIL rstmid_wr_quiet got=%0d exp=0", nresp); end
    endtask

    task automatic test_back_to_back(input int nops);
        logic [1:0]  q_op[$];
        logic [15:0] q_rd[$];
        int          q_cyc[$];
        int issued, done_cnt, cyc, bad, consec;
        logic pwe;
        logic [1:0] op, o;
        logic [15:0] a, w, r;
        int d;
        issued = 0; done_cnt = 0; cyc = 0; bad = 0; consec = 0; pwe = 1'b0;
        for (int i = 0; i < 32; i++) poke(16'h0100 + 16'(i), 16'h0100 + 16'($urandom_range(0, 31)));
        while ((issued < nops || done_cnt < issued) && cyc < nops * 12 + 50) begin
            if (mem_write_en && pwe) consec++;
            pwe = mem_write_en;
            if (resp_valid) begin
                checks++;
                if (q_op.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious_resp cyc=%0d got=1 exp=0", cyc);
                end else begin
                    o = q_op.pop_front(); r = q_rd.pop_front(); d = q_cyc.pop_front();
                    if (cyc - d !== exp_latency(o)) begin
                        errors++; $display("FAIL b2b_latency op=%0d got=%0d exp=%0d", o, cyc - d, exp_latency(o));
                    end
                    if (!o[0]) begin
                        checks++;
                        if (resp_rdata !== r) begin errors++; $display("FAIL b2b_rdata op=%0d got=%h exp=%h", o, resp_rdata, r); end
                    end
                    done_cnt++;
                end
            end
            if (req_ready && issued < nops) begin
                op = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0: a = 16'hFFFF;
                    1: a = 16'h0000;
                    default: a = 16'h0100 + 16'($urandom_range(0, 31));
                endcase
                w = $urandom_range(0, 1) ? 16'h0100 + 16'($urandom_range(0, 31)) : 16'($urandom);
                req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
                r = model(op, a, w);
                q_op.push_back(op); q_rd.push_back(r); q_cyc.push_back(cyc);
                issued++;
            end else begin
                req_valid = (issued < nops);
                req_op    = 2'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        checks++; if (done_cnt !== nops) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", done_cnt, nops); end
        checks++; if (consec !== 0) begin errors++; $display("FAIL b2b_we_consecutive got=%0d exp=0", consec); end
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_memory got=%0d bad words exp=0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_read_ind();
        test_write_ind();
        test_self_ptr();
        test_reset_mid();
        test_back_to_back(60);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
